// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with run-time parity mode and stop-bit count.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module uart_rx_cfg #(
   parameter int DATA_BITS = 8,
   parameter int OS_RATE   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_tick,
   input  logic [1:0]           cfg_parity,
   input  logic                 cfg_two_stop,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_break,
   input  logic                 RX
);
   localparam int OSW = $clog2(OS_RATE);
   localparam int BW  = $clog2(DATA_BITS + 1);
   localparam logic [OSW-1:0] OS_ONE = OSW'(1);
   localparam logic [OSW-1:0] MID    = OSW'(OS_RATE / 2 - 1);
   localparam logic [OSW-1:0] LAST   = OSW'(OS_RATE - 1);
   localparam logic [BW-1:0]  BW_ONE = BW'(1);
   localparam logic [BW-1:0]  NBITS  = BW'(DATA_BITS);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] PARITY    = 3'd3;
   localparam logic [2:0] STOP      = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;
   localparam logic [2:0] WAIT_HIGH = 3'd6;

   logic [1:0]           sync;
   logic                 rx_sync;
   logic [2:0]           state;
   logic [OSW-1:0]       os_cnt;
   logic [BW-1:0]        bit_i;
   logic [DATA_BITS-1:0] shift;
   logic [1:0]           par_mode;
   logic                 two_stop;
   logic                 second_stop;
   logic                 par_bit;
   logic                 par_err;
   logic                 frame_err;
   logic                 par_en;
   logic                 last_stop;
   logic                 frame_err_nxt;
   logic                 sample;
   logic [OSW-1:0]       samp_pt;

   assign rx_sync       = sync[1];
   assign par_en        = (par_mode == 2'd1) || (par_mode == 2'd2);
   assign last_stop     = !two_stop || second_stop;
   assign frame_err_nxt = frame_err | ~sample;

   always_ff @(posedge clk) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], RX};
   end

`ifdef UART_RX_MAJORITY_EN
   // Vote over ticks mid-1, mid and mid+1; all sample actions land on mid+1.
   logic [1:0] hist;
   localparam logic [OSW-1:0] MID_M1 = OSW'(OS_RATE / 2 - 2);
   assign samp_pt = OSW'(OS_RATE / 2);
   assign sample  = (hist[0] & hist[1]) | (hist[0] & rx_sync) | (hist[1] & rx_sync);

   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= 2'b11;
      end else if (rx_tick) begin
         if (os_cnt == MID_M1) hist[0] <= rx_sync;
         if (os_cnt == MID)    hist[1] <= rx_sync;
      end
   end
`else
   assign samp_pt = MID;
   assign sample  = rx_sync;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         os_cnt        <= '0;
         bit_i         <= '0;
         shift         <= '0;
         par_mode      <= 2'd0;
         two_stop      <= 1'b0;
         second_stop   <= 1'b0;
         par_bit       <= 1'b0;
         par_err       <= 1'b0;
         frame_err     <= 1'b0;
         rx_valid      <= 1'b0;
         rx_data       <= '0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_break      <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: if (rx_tick && !rx_sync) begin
               // Configuration is frozen for the whole frame from here on.
               par_mode    <= cfg_parity;
               two_stop    <= cfg_two_stop;
               shift       <= '0;
               par_bit     <= 1'b0;
               par_err     <= 1'b0;
               frame_err   <= 1'b0;
               second_stop <= 1'b0;
               os_cnt      <= OS_ONE;
               state       <= START;
            end
            START: if (rx_tick) begin
               os_cnt <= os_cnt + OS_ONE;
               if (os_cnt == samp_pt && sample) begin
                  os_cnt <= '0;
                  state  <= IDLE;
               end else if (os_cnt == LAST) begin
                  bit_i <= '0;
                  state <= DATA;
               end
            end
            DATA: if (rx_tick) begin
               os_cnt <= os_cnt + OS_ONE;
               if (os_cnt == samp_pt) begin
                  for (int i = 0; i < DATA_BITS; i++)
                     if (bit_i == BW'(i)) shift[i] <= sample;
                  bit_i <= bit_i + BW_ONE;
               end
               if (os_cnt == LAST && bit_i == NBITS)
                  state <= par_en ? PARITY : STOP;
            end
            PARITY: if (rx_tick) begin
               os_cnt <= os_cnt + OS_ONE;
               if (os_cnt == samp_pt) begin
                  par_bit <= sample;
                  par_err <= ((^shift) ^ sample) != (par_mode == 2'd1);
               end
               if (os_cnt == LAST) state <= STOP;
            end
            STOP: if (rx_tick) begin
               os_cnt <= os_cnt + OS_ONE;
               if (os_cnt == samp_pt) begin
                  frame_err <= frame_err_nxt;
                  // Finish at the middle of the last stop bit so back-to-back frames are caught.
                  if (last_stop) begin
                     rx_valid      <= 1'b1;
                     rx_data       <= shift;
                     rx_parity_err <= par_en & par_err;
                     rx_frame_err  <= frame_err_nxt;
                     rx_break      <= frame_err_nxt & ~|shift & ~(par_en & par_bit);
                     os_cnt        <= '0;
                     state         <= DONE;
                  end
               end
               if (os_cnt == LAST) second_stop <= 1'b1;
            end
            DONE: begin
               os_cnt <= '0;
               state  <= frame_err ? WAIT_HIGH : IDLE;
            end
            WAIT_HIGH: if (rx_tick && rx_sync) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomised frames
// scored against a frame-level reference model.
module tb_uart_rx_cfg;
   localparam int DATA_BITS = 8;
   localparam int OS_RATE   = 16;
   localparam int W         = DATA_BITS + 3;
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT = 154;
`else
   localparam int LAT = 153;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 rx_tick;
   logic [1:0]           cfg_parity;
   logic                 cfg_two_stop;
   logic                 rx_valid;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_parity_err;
   logic                 rx_frame_err;
   logic                 rx_break;
   logic                 RX;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] sb_exp;
   int checks    = 0;
   int errors    = 0;
   int valid_cnt = 0;
   int tick_div  = 1;
   int tick_cnt  = 0;

   uart_rx_cfg #(.DATA_BITS(DATA_BITS), .OS_RATE(OS_RATE)) dut (
      .clk(clk), .rst(rst), .rx_tick(rx_tick), .cfg_parity(cfg_parity),
      .cfg_two_stop(cfg_two_stop), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
      .rx_break(rx_break), .RX(RX)
   );

   // clock / tick generation
   always #5 clk = ~clk;

   initial begin
      rx_tick = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tick_cnt++;
         if (tick_cnt >= tick_div) begin
            rx_tick  = 1'b1;
            tick_cnt = 0;
         end else begin
            rx_tick = 1'b0;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // reference model: expected {break, frame_err, parity_err, data} of one frame
   function automatic logic [W-1:0] model(input logic [DATA_BITS-1:0] d, input int pmode,
                                          input bit two, input bit pbit, input bit s1, input bit s2);
      int ones = 0;
      bit pen, perr, ferr, brk;
      for (int i = 0; i < DATA_BITS; i++) ones += int'(d[i]);
      pen  = (pmode == 1) || (pmode == 2);
      perr = pen && (((ones + int'(pbit)) % 2) != ((pmode == 1) ? 1 : 0));
      ferr = !s1 || (two && !s2);
      brk  = ferr && (d == 0) && (!pen || !pbit);
      return {brk, ferr, perr, d};
   endfunction

   function automatic bit good_par(input logic [DATA_BITS-1:0] d, input int pmode);
      int ones = 0;
      for (int i = 0; i < DATA_BITS; i++) ones += int'(d[i]);
      return (pmode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
   endfunction

   // driver tasks
   task automatic wait_ticks(input int n);
      int c = 0;
      while (c < n) begin
         @(posedge clk);
         if (rx_tick) c++;
      end
      #2;
   endtask

   task automatic send_bit(input bit v);
      RX = v;
      wait_ticks(OS_RATE);
   endtask

   task automatic send_raw(input logic [DATA_BITS-1:0] d, input int pmode, input bit two,
                           input bit pbit, input bit s1, input bit s2, input bit scramble);
      cfg_parity   = 2'(pmode);
      cfg_two_stop = two;
      exp_q.push_back(model(d, pmode, two, pbit, s1, s2));
      send_bit(1'b0);
      if (scramble) begin
         cfg_parity   = 2'($urandom_range(0, 3));
         cfg_two_stop = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
      if (pmode == 1 || pmode == 2) send_bit(pbit);
      send_bit(s1);
      if (two) send_bit(s2);
   endtask

   task automatic drain();
      for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
   endtask

   // scoreboard
   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid got=%h", {rx_break, rx_frame_err, rx_parity_err, rx_data});
         end else begin
            sb_exp = exp_q.pop_front();
            if ({rx_break, rx_frame_err, rx_parity_err, rx_data} !== sb_exp) begin
               errors++;
               $display("FAIL frame got=%h exp=%h", {rx_break, rx_frame_err, rx_parity_err, rx_data}, sb_exp);
            end
         end
      end
   end

   // scenarios
   task automatic test_reset();
      rst = 1'b1; RX = 1'b1; cfg_parity = 2'd0; cfg_two_stop = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0", {rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break});
      end
      checks++;
      if (dut.state !== 3'd0) begin
         errors++;
         $display("FAIL reset_state got=%0d exp=0", dut.state);
      end
      rst = 1'b0;
      wait_ticks(2 * OS_RATE);
   endtask

   task automatic test_latency();
      tick_div = 1;
      wait_ticks(2 * OS_RATE);
      fork
         send_raw(8'hA5, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         begin
            for (int e = 0; e <= LAT; e++) begin
               @(posedge clk);
               #1;
               if (e == LAT - 1) begin
                  checks++;
                  if (rx_valid !== 1'b0) begin
                     errors++;
                     $display("FAIL latency_early got=%b exp=0", rx_valid);
                  end
               end
               if (e == LAT) begin
                  checks++;
                  if ({rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break} !== {1'b1, 8'hA5, 3'b000}) begin
                     errors++;
                     $display("FAIL latency_frame got=%h exp=%h",
                              {rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break}, {1'b1, 8'hA5, 3'b000});
                  end
               end
            end
         end
      join
      drain();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL latency_drain left=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_parity();
      send_raw(8'h3C, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL parity_even_ok got=%b exp=0", rx_parity_err); end
      send_raw(8'h3D, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (rx_parity_err !== 1'b1) begin errors++; $display("FAIL parity_even_bad got=%b exp=1", rx_parity_err); end
      send_raw(8'h3D, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (rx_parity_err !== 1'b0) begin errors++; $display("FAIL parity_odd_ok got=%b exp=0", rx_parity_err); end
      drain();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL parity_drain left=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int v0 = valid_cnt;
      send_raw(8'h55, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_raw(8'h0F, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      drain();
      checks++;
      if (valid_cnt - v0 != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", valid_cnt - v0); end
      checks++;
      if (rx_data !== 8'h0F) begin errors++; $display("FAIL b2b_last got=%h exp=0f", rx_data); end
   endtask

   task automatic test_break();
      int v0 = valid_cnt;
      cfg_parity = 2'd0; cfg_two_stop = 1'b0;
      exp_q.push_back(model('0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
      RX = 1'b0;
      wait_ticks(20 * OS_RATE);
      checks++;
      if (valid_cnt - v0 != 1) begin errors++; $display("FAIL break_count got=%0d exp=1", valid_cnt - v0); end
      RX = 1'b1;
      wait_ticks(2 * OS_RATE);
      checks++;
      if (valid_cnt - v0 != 1) begin errors++; $display("FAIL break_recover got=%0d exp=1", valid_cnt - v0); end
      send_raw(8'h5A, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drain();
      checks++;
      if (valid_cnt - v0 != 2) begin errors++; $display("FAIL break_next got=%0d exp=2", valid_cnt - v0); end
   endtask

   task automatic test_false_start();
      int v0 = valid_cnt;
      RX = 1'b0;
      wait_ticks(4);
      RX = 1'b1;
      wait_ticks(3 * OS_RATE);
      checks++;
      if (valid_cnt != v0) begin errors++; $display("FAIL glitch_valid got=%0d exp=%0d", valid_cnt, v0); end
      checks++;
      if (dut.state !== 3'd0) begin errors++; $display("FAIL glitch_state got=%0d exp=0", dut.state); end
      checks++;
      if (rx_data !== 8'h5A) begin errors++; $display("FAIL glitch_hold got=%h exp=5a", rx_data); end
   endtask

   task automatic test_reset_midframe();
      int v0 = valid_cnt;
      RX = 1'b0;
      wait_ticks(OS_RATE);
      RX = 1'b1;
      wait_ticks(3 * OS_RATE + OS_RATE / 2);
      rst = 1'b1;
      @(posedge clk);
      #2;
      checks++;
      if ({rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs got=%h exp=0", {rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_break});
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_ticks(2 * OS_RATE);
      checks++;
      if (valid_cnt != v0) begin errors++; $display("FAIL midreset_valid got=%0d exp=%0d", valid_cnt, v0); end
      send_raw(8'h81, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drain();
      checks++;
      if (rx_data !== 8'h81) begin errors++; $display("FAIL midreset_next got=%h exp=81", rx_data); end
   endtask

   task automatic test_random();
      int v0 = valid_cnt;
      for (int n = 0; n < 16; n++) begin
         logic [DATA_BITS-1:0] d;
         int pmode;
         bit two, bad_par, bad_stop, pbit;
         tick_div = $urandom_range(1, 3);
         d        = ($urandom_range(0, 7) == 0) ? '0 : DATA_BITS'($urandom);
         pmode    = $urandom_range(0, 3);
         two      = 1'($urandom_range(0, 1));
         bad_par  = ($urandom_range(0, 3) == 0);
         bad_stop = ($urandom_range(0, 3) == 0);
         pbit     = good_par(d, pmode) ^ bad_par;
         send_raw(d, pmode, two, pbit, !bad_stop, 1'b1, 1'b1);
         if (bad_stop || $urandom_range(0, 1) == 1) send_bit(1'b1);
      end
      drain();
      checks++;
      if (valid_cnt - v0 != 16) begin errors++; $display("FAIL random_count got=%0d exp=16", valid_cnt - v0); end
      tick_div = 1;
   endtask

   initial begin
      RX = 1'b1; rst = 1'b1; cfg_parity = 2'd0; cfg_two_stop = 1'b0;
      test_reset();
      test_latency();
      test_parity();
      test_back_to_back();
      test_break();
      test_false_start();
      test_reset_midframe();
      test_random();
      repeat (10) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver that succeeds the fixed 8N1 receiver.
- Data width and oversampling rate are set by parameters.
- Parity mode (none/odd/even) and stop-bit count (1/2) are selectable at run time.
- Reports parity, framing and break errors alongside each received word.
- Sits between the pin-side RX line and user logic; driven by the shared baud-tick generator.

Parameters:
- DATA_BITS, 8, data bits per frame; legal 5..9; sent LSB first.
- OS_RATE, 16, rx_tick pulses per bit period; power of two, 8..64.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rx_tick  in  1  oversample strobe, OS_RATE×baud, at most one clk wide.
- cfg_parity  in  2  0=none, 1=odd, 2=even, 3=none.
- cfg_two_stop  in  1  1=two stop bits.
- rx_valid  out  1  one-clk pulse per completed frame.
- rx_data  out  DATA_BITS  received word.
- rx_parity_err  out  1  parity mismatch for the current word.
- rx_frame_err  out  1  a sampled stop bit was 0.
- rx_break  out  1  line held low for the whole frame.
- RX  in  1  asynchronous serial line, idle high.

Behaviour:
- RX passes through a 2-FF synchroniser (both FFs reset to 1) to give RX_sync; all decisions use RX_sync.
- Counters: os_cnt is log2(OS_RATE) bits and wraps naturally; bit_i is log2(DATA_BITS+1) bits. "Mid" means os_cnt==OS_RATE/2-1; "end" means os_cnt==OS_RATE-1.
- Outside DONE, state and counters advance only on clk edges where rx_tick=1.
- IDLE: on a tick with RX_sync=0, latch cfg_parity and cfg_two_stop, set os_cnt=1, go to START. Config changes mid-frame are ignored.
- START: os_cnt++ each tick.
  - At mid, if RX_sync=1: false start; go to IDLE with os_cnt=0.
  - At end: go to DATA with os_cnt=0, bit_i=0.
- DATA: os_cnt++ each tick.
  - At mid: shift RX_sync into bit bit_i, then bit_i++.
  - At end with bit_i==DATA_BITS: go to PARITY if parity is enabled, else STOP; os_cnt=0.
- PARITY: at mid, parity_err = (XOR of data bits ^ sampled bit) != (odd?1:0). At end, go to STOP.
- STOP: at mid of each stop bit, OR the inverse of RX_sync into frame_err.
  - At mid of the last stop bit, go to DONE; the second half of the stop bit is not waited for, so back-to-back frames are accepted.
  - In two-stop mode the first stop bit runs to end, then os_cnt=0 and the second stop bit begins.
- DONE: lasts exactly one clk and ignores rx_tick.
  - rx_valid=1; rx_data, rx_parity_err and rx_frame_err are registered.
  - rx_break = frame_err & (data==0) & (parity bit==0 or parity disabled).
  - Next state is WAIT_HIGH if frame_err, else IDLE; os_cnt=0.
- WAIT_HIGH: on a tick with RX_sync=1, go to IDLE. This prevents a held-low line or break from re-triggering.
- Outputs are registered.
  - rx_data and the three error flags hold their values until the next DONE.
  - rx_parity_err is always 0 when parity is disabled.
- Reset: state IDLE, os_cnt=0, bit_i=0, rx_valid=0, rx_data=0, all error flags 0, synchroniser=1.
- Reset mid-frame discards the partial word with no rx_valid; outputs return to reset values on the next clk.
- Latency with rx_tick tied high, 8N1, OS_RATE=16: RX falls before edge 0; START is entered at edge 2; rx_valid is high on the cycle after edge 153 (sampled at edge 154).

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample point (start check, data, parity, stop) uses the 2-of-3 majority of RX_sync at ticks mid-1, mid and mid+1. The decision and counter actions take effect at mid+1; the state transition stays at end, or at mid+1 for the last stop bit.
- Undefined: single sample at mid, with no extra registers.

Test Plan:
1. Defaults, rx_tick=1 every clk, send 0xA5 8N1 -> one rx_valid pulse at edge 154; rx_data=0xA5; all error flags 0.
2. cfg_parity=2 (even), send 0x3C with parity bit 0, then 0x3D with parity bit 0 -> first word: rx_parity_err=0; second word: rx_parity_err=1.
3. cfg_two_stop=1, send 0x55 then 0x0F back-to-back -> two rx_valid pulses, 0x55 then 0x0F, no errors.
4. Hold RX=0 for 20 bit times -> exactly one rx_valid with rx_data=0x00, rx_frame_err=1, rx_break=1; no further rx_valid until RX returns high and a new start bit arrives.
5. RX low glitch of 4 ticks -> false start; no rx_valid; state back to IDLE.
6. Assert rst at data bit 3 of a frame -> rx_valid stays 0; outputs are 0; the next frame 0x81 is received correctly.
